// File: rtl/ibf_extract_pipe.sv
// Mode-driven field extractor: per-mode {en, offset, len} lookup from a
// double-buffered config table, unit-granular log shifter with selectable
// pipeline registers, length mask, drop counting, credit-throttled input and
// a show-ahead output FIFO.
module ibf_extract_pipe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned UNIT       = 8,
  parameter int unsigned MODE_WIDTH = 2,
  parameter logic [$clog2(DATA_WIDTH/UNIT)-1:0] PIPED_MASK = 3'b101,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned SH_STAGES = $clog2(DATA_WIDTH/UNIT),
  localparam int unsigned OFF_W     = SH_STAGES,
  localparam int unsigned LEN_W     = $clog2(OUT_WIDTH/UNIT) + 1,
  localparam int unsigned CFG_W     = 1 + OFF_W + LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic [MODE_WIDTH-1:0] mode_o,
  input  logic                  cfg_wr_en,
  input  logic [MODE_WIDTH-1:0] cfg_wr_mode,
  input  logic [CFG_W-1:0]      cfg_wr_data,
  input  logic                  cfg_commit,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned NUM_MODES = 2 ** MODE_WIDTH;
  localparam int unsigned OUT_UNITS = OUT_WIDTH / UNIT;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + SH_STAGES + 3) + 1;

  // Beat plus the config it was accepted with; travels through the shifter.
  typedef struct packed {
    logic                  valid;
    logic                  en;
    logic [OFF_W-1:0]      off;
    logic [LEN_W-1:0]      len;
    logic [MODE_WIDTH-1:0] mode;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef struct packed {
    logic                  valid;
    logic                  en;
    logic [MODE_WIDTH-1:0] mode;
    logic [OUT_WIDTH-1:0]  data;
  } exit_t;

  typedef logic [MODE_WIDTH+OUT_WIDTH-1:0] ent_t;

  // ---------------------------------------------------------------------------
  // Config tables
  // ---------------------------------------------------------------------------
  logic [CFG_W-1:0] shadow_q [NUM_MODES];
  logic [CFG_W-1:0] shadow_d [NUM_MODES];
  logic [CFG_W-1:0] active_q [NUM_MODES];
  logic [CFG_W-1:0] active_d [NUM_MODES];

  // Shadow write; commit copies the post-write shadow so a same-cycle write lands.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_wr_en) shadow_d[cfg_wr_mode] = cfg_wr_data;
    active_d = active_q;
    if (cfg_commit) active_d = shadow_d;
  end

  // Table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MODES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic  accept;
  beat_t in_q, in_d;

  assign accept = valid_i & ready_o;

  // Capture beat with its active-table entry; old table applies on a commit edge.
  always_comb begin
    in_d       = in_q;
    in_d.valid = accept;
    if (accept) begin
      in_d.en   = active_q[mode_i][CFG_W-1];
      in_d.off  = active_q[mode_i][LEN_W +: OFF_W];
      in_d.len  = active_q[mode_i][LEN_W-1:0];
      in_d.mode = mode_i;
      in_d.data = data_i;
    end
  end

  // Input beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= in_d;
  end

  // ---------------------------------------------------------------------------
  // Log shifter with optional per-stage registers
  // ---------------------------------------------------------------------------
  beat_t pipe_q [SH_STAGES];
  beat_t pipe_d [SH_STAGES];
  beat_t last;

  // Stage k shifts by 2^k units; a piped stage hands the next stage its register.
  always_comb begin
    beat_t cur;
    cur = in_q;
    for (int k = 0; k < SH_STAGES; k++) begin
      if (cur.off[k]) cur.data = cur.data >> ((1 << k) * UNIT);
      pipe_d[k] = cur;
      if (PIPED_MASK[k]) cur = pipe_q[k];
    end
    last = cur;
  end

  // Stage registers; unpiped slots stay at their reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SH_STAGES; k++) pipe_q[k] <= '0;
    end else begin
      for (int k = 0; k < SH_STAGES; k++) begin
        if (PIPED_MASK[k]) pipe_q[k] <= pipe_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Length mask and exit register
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] field_mask;
  exit_t                exit_q, exit_d;
  logic                 unused_last;

  assign unused_last = ^{last.off, last.data};

  // len of zero or at least a full field keeps every output bit.
  always_comb begin
    field_mask = '1;
    if ((last.len != '0) && (32'(last.len) < OUT_UNITS)) begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
        field_mask[i] = (32'(i) < 32'(last.len) * UNIT);
      end
    end
    exit_d.valid = last.valid;
    exit_d.en    = last.en;
    exit_d.mode  = last.mode;
    exit_d.data  = last.data[OUT_WIDTH-1:0] & field_mask;
  end

  // Exit register: the beat leaves the pipeline from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exit_q <= '0;
    else        exit_q <= exit_d;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO and drop counter
  // ---------------------------------------------------------------------------
  ent_t             mem_q [FIFO_DEPTH];
  ent_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic             push, pop;

  assign push    = exit_q.valid & exit_q.en;
  assign valid_o = (cnt_q != '0);
  assign pop     = valid_o & ready_i;
  assign {mode_o, data_o} = mem_q[rd_ptr_q];
  assign drop_cnt = drop_q;

  // FIFO pointers/count and saturating drop count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {exit_q.mode, exit_q.data};
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    drop_d = drop_q;
    if (exit_q.valid && !exit_q.en && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // FIFO and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit: every registered beat plus FIFO entries, never from ready_i/valid_i
  // ---------------------------------------------------------------------------
  logic [OCC_W-1:0] occ;

  // Count registered in-flight beats; a dropped beat's credit frees at exit.
  always_comb begin
    occ = OCC_W'(cnt_q) + OCC_W'(in_q.valid) + OCC_W'(exit_q.valid);
    for (int k = 0; k < SH_STAGES; k++) begin
      if (PIPED_MASK[k]) occ = occ + OCC_W'(pipe_q[k].valid);
    end
  end

  assign ready_o = (occ < OCC_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_ibf_extract_pipe.sv
// Directed bench for ibf_extract_pipe with a transaction-level reference model
// checked on every cycle, plus literal expectations for the key scenarios.
module tb_ibf_extract_pipe;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam logic [63:0] D = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  mode_i = 2'd0;
  logic [63:0] data_i = 64'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] data_o;
  logic [1:0]  mode_o;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_wr_mode = 2'd0;
  logic [5:0]  cfg_wr_data = 6'd0;
  logic        cfg_commit = 1'b0;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_pops = 0;

  ibf_extract_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .mode_i     (mode_i),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .mode_o     (mode_o),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_wr_mode(cfg_wr_mode),
    .cfg_wr_data(cfg_wr_data),
    .cfg_commit (cfg_commit),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Extracted field from plain arithmetic: shift by offset bytes, keep len bytes.
  function automatic logic [15:0] field(input logic [63:0] d, input logic [5:0] c);
    logic [63:0] s;
    int          nb;
    s = d >> (int'(c[4:2]) * 8);
    if (c[1:0] == 2'd0 || c[1:0] >= 2'd2) nb = 16;
    else nb = int'(c[1:0]) * 8;
    if (nb == 16) return s[15:0];
    return s[15:0] & 16'((32'd1 << nb) - 1);
  endfunction

  // Reference model: queue of expected outputs with availability cycle, and
  // pending drops with their exit cycle. Checked every negedge.
  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    int          avail;
  } exp_t;

  initial begin : model
    exp_t        eq[$];
    int          dq[$];
    int          drops_done;
    int          occ;
    logic        exp_ready, exp_valid;
    logic [5:0]  m_sh[4];
    logic [5:0]  m_act[4];
    logic [5:0]  c;
    exp_t        e;
    drops_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eq.delete();
        dq.delete();
        drops_done = 0;
        for (int i = 0; i < 4; i++) begin
          m_sh[i]  = 6'd0;
          m_act[i] = 6'd0;
        end
      end else begin
        while (dq.size() > 0 && dq[0] <= cyc) begin
          void'(dq.pop_front());
          drops_done++;
        end
        occ       = eq.size() + dq.size();
        exp_ready = (occ < DEPTH);
        exp_valid = (eq.size() > 0) && (eq[0].avail <= cyc);
        chk("ready_o", 64'(ready_o), 64'(exp_ready));
        chk("valid_o", 64'(valid_o), 64'(exp_valid));
        chk("drop_cnt", 64'(drop_cnt), 64'((drops_done > 65535) ? 65535 : drops_done));
        if (valid_o && ready_i) dut_pops++;
        if (exp_valid) begin
          chk("data_o", 64'(data_o), 64'(eq[0].data));
          chk("mode_o", 64'(mode_o), 64'(eq[0].mode));
          if (ready_i) void'(eq.pop_front());
        end
        if (valid_i && exp_ready) begin
          c = m_act[mode_i];
          if (c[5]) begin
            e.data  = field(data_i, c);
            e.mode  = mode_i;
            e.avail = cyc + 1 + LAT;
            eq.push_back(e);
          end else begin
            dq.push_back(cyc + 1 + LAT);
          end
        end
        if (cfg_wr_en) m_sh[cfg_wr_mode] = cfg_wr_data;
        if (cfg_commit) m_act = m_sh;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] m, input logic [5:0] d, input logic commit);
    cfg_wr_en   = 1'b1;
    cfg_wr_mode = m;
    cfg_wr_data = d;
    cfg_commit  = commit;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] d);
    int t;
    valid_i = 1'b1;
    mode_i  = m;
    data_i  = d;
    t = 0;
    while (!ready_o && t < 100) begin
      tick();
      t++;
    end
    if (!ready_o) chk("send_timeout", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!valid_o && t < 20) begin
      tick();
      t++;
    end
    chk(nm, 64'(valid_o), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int full_at;
    int t;
    int pops0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_mode_o", 64'(mode_o), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    tick();

    // Drop: mode0 disabled after reset
    for (int i = 0; i < 3; i++) send(2'd0, D + 64'(i));
    repeat (8) tick();
    chk("drop_cnt3", 64'(drop_cnt), 64'd3);
    chk("drop_no_valid", 64'(valid_o), 64'd0);
    chk("drop_ready", 64'(ready_o), 64'd1);

    // Configure modes 1..3 then commit
    cfg_write(2'd1, {1'b1, 3'd2, 2'd0}, 1'b0);
    cfg_write(2'd2, {1'b1, 3'd0, 2'd1}, 1'b0);
    cfg_write(2'd3, {1'b1, 3'd7, 2'd0}, 1'b0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;

    // Basic shift with latency pin
    send(2'd1, D);
    repeat (3) tick();
    chk("lat_early", 64'(valid_o), 64'd0);
    tick();
    chk("lat_valid", 64'(valid_o), 64'd1);
    chk("basic_data", 64'(data_o), 64'h5566);
    chk("basic_mode", 64'(mode_o), 64'd1);
    tick();

    // Length mask and max offset
    send(2'd2, D);
    wait_valid("m2_valid");
    chk("m2_data", 64'(data_o), 64'h0088);
    tick();
    send(2'd3, D);
    wait_valid("m3_valid");
    chk("m3_data", 64'(data_o), 64'h0011);
    chk("m3_mode", 64'(mode_o), 64'd3);
    tick();
    repeat (2) tick();

    // Backpressure: 20 beats with downstream stalled until credits run out
    pops0   = dut_pops;
    ready_i = 1'b0;
    full_at = -1;
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      mode_i  = 2'd1;
      data_i  = (64'(i + 1) << 16) | 64'h00AA;
      if (!ready_o) begin
        if (full_at < 0) begin
          full_at = i;
          repeat (3) tick();
          chk("bp_held", 64'(ready_o), 64'd0);
          ready_i = 1'b1;
        end
        t = 0;
        while (!ready_o && t < 100) begin
          tick();
          t++;
        end
        if (!ready_o) chk("bp_timeout", 64'(ready_o), 64'd1);
      end
      tick();
    end
    valid_i = 1'b0;
    chk("bp_full_at", 64'(full_at), 64'd8);
    repeat (20) tick();
    chk("bp_pops", 64'(dut_pops - pops0), 64'd20);

    // Reconfig: shadow-only write leaves active table alone
    cfg_write(2'd1, {1'b1, 3'd0, 2'd0}, 1'b0);
    send(2'd1, D);
    wait_valid("rc_shadow_valid");
    chk("rc_shadow_data", 64'(data_o), 64'h5566);
    tick();
    // Write+commit on an accept edge: that beat old table, next beat new
    valid_i     = 1'b1;
    mode_i      = 2'd1;
    data_i      = D;
    cfg_wr_en   = 1'b1;
    cfg_wr_mode = 2'd1;
    cfg_wr_data = {1'b1, 3'd0, 2'd0};
    cfg_commit  = 1'b1;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    tick();
    valid_i = 1'b0;
    wait_valid("rc_a_valid");
    chk("rc_a_data", 64'(data_o), 64'h5566);
    tick();
    chk("rc_b_valid", 64'(valid_o), 64'd1);
    chk("rc_b_data", 64'(data_o), 64'h7788);
    repeat (3) tick();

    // Async reset with five beats buffered
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd1, D + 64'(i));
    repeat (6) tick();
    chk("ar_pre_valid", 64'(valid_o), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_o", 64'(valid_o), 64'd0);
    chk("ar_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("ar_data_o", 64'(data_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ready_i = 1'b1;
    tick();
    send(2'd1, D);
    repeat (8) tick();
    chk("ar_post_drop", 64'(drop_cnt), 64'd1);
    chk("ar_post_valid", 64'(valid_o), 64'd0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
